// File: rtl/fetch_queue.sv
// fetch_queue: front-end fetch with static branch/jump
// prediction feeding a show-ahead decoupling FIFO.
package fetch_queue_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } fq_entry_t;
endpackage

module fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] HLT_INST = 32'hFC00_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic [31:0]             imem_addr,
  input  logic [31:0]             imem_data,
  input  logic                    deq_ready,
  output logic                    deq_valid,
  output logic [31:0]             deq_inst,
  output logic [31:0]             deq_pc,
  output logic                    deq_pred_taken,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    halted
);
  import fetch_queue_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [31:0] fetch_pc;
  logic        halted_q;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  fq_entry_t   mem [DEPTH];
  fq_entry_t   head;

  logic [5:0]  op;
  logic        is_hlt;
  logic        is_br;
  logic        is_jmp;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic        pred;
  logic        enq;
  logic        deq;

  // Halt wins any opcode overlap so the decode stays one-hot.
  always_comb begin
    op      = imem_data[31:26];
    is_hlt  = (imem_data == HLT_INST);
    is_br   = !is_hlt && (op == 6'h04 || op == 6'h05);
    is_jmp  = !is_hlt && (op == 6'h02 || op == 6'h03);
    br_off  = {{16{imem_data[15]}}, imem_data[15:0]};
    next_pc = fetch_pc + 32'd1;
    pred    = 1'b0;
    unique case (1'b1)
      is_hlt: next_pc = fetch_pc;
      is_br: begin
        next_pc = fetch_pc + br_off;
        pred    = 1'b1;
      end
      is_jmp: begin
        next_pc = {fetch_pc[31:26], imem_data[25:0]};
        pred    = 1'b1;
      end
      default: ;
    endcase
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);

  // Full is taken before any same-cycle pop.
  assign enq = !redirect_valid && !halted_q && !full;
  assign deq = !redirect_valid && deq_valid && deq_ready;

  assign head           = mem[rd_ptr[AW-1:0]];
  assign deq_valid      = !empty;
  assign deq_inst       = empty ? 32'd0 : head.inst;
  assign deq_pc         = empty ? 32'd0 : head.pc;
  assign deq_pred_taken = empty ? 1'b0 : head.pred;

  assign imem_addr = fetch_pc;
  assign halted    = halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      halted_q <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      rd_ptr   <= wr_ptr;
      fetch_pc <= redirect_pc;
      halted_q <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= next_pc;
        if (is_hlt)
          halted_q <= 1'b1;
      end
      if (deq)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq)
      mem[wr_ptr[AW-1:0]] <= '{
        inst: imem_data,
        pc:   fetch_pc,
        pred: pred
      };
  end

endmodule
